// File: rtl/colorbuff_fifo_if.sv
// Handshake and status bundle between the pixel source, colorbuff_fifo and the RLE encoder.
// The slave modport is the buffer itself; the master modport is the source/encoder side.
// Status (count/full/empty/out_run) rides along so the encoder sees one bundle.
interface colorbuff_fifo_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int RUN_W  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_same;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic [RUN_W-1:0]  out_run;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_same, count, full, empty, out_run
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_same, count, full, empty, out_run
  );
endinterface

// File: rtl/colorbuff_fifo.sv
// Color word FIFO with show-ahead head and "head equals last popped word" flag for the RLE path.
// Latency: a word pushed at edge N is visible at out_data/out_valid in cycle N+1; no empty bypass.
// Backpressure: in_ready = !full (a pop in a full cycle frees space only from the next cycle).
// Optional run-length counter on out_run enabled by defining COLORBUFF_RUN_EN; otherwise out_run = 0.
module colorbuff_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int RUN_W  = 8
) (
  input  logic           clock,
  input  logic           reset,
  colorbuff_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] last_word_q, last_word_d;
  logic              last_vld_q, last_vld_d;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic              head_same;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign head      = mem[rd_ptr_q];
  // Full refuses a push even when a pop happens in the same cycle.
  assign push      = bus.in_valid && !full;
  assign pop       = bus.out_ready && !empty;
  assign head_same = last_vld_q && (head == last_word_q);

  // Next-state for pointers, occupancy and the last-popped word.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_word_d = last_word_q;
    last_vld_d  = last_vld_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      last_word_d = head;
      last_vld_d  = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset drops stored words at once, last_word survives only empty periods.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_word_q <= '0;
      last_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_word_q <= last_word_d;
      last_vld_q  <= last_vld_d;
    end
  end

  // Storage array; contents are left alone by reset since the pointers make them unreachable.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = head;
  assign bus.out_same  = !empty && head_same;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;

`ifdef COLORBUFF_RUN_EN
  logic [RUN_W-1:0] run_q, run_d;

  // Run length of identical popped words, saturating at all-ones.
  always_comb begin
    run_d = run_q;
    if (pop) begin
      if (head_same) begin
        if (run_q != '1) begin
          run_d = run_q + RUN_W'(1);
        end
      end else begin
        run_d = RUN_W'(1);
      end
    end
  end

  // Run counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  assign bus.out_run = run_q;
`else
  assign bus.out_run = '0;
`endif

endmodule

// File: tb/tb_colorbuff_fifo.sv
// Directed self-checking bench for colorbuff_fifo (DEPTH=8, DATA_W=32).
// Covers reset, ordered fill/drain, full boundary, run flag, wrap streaming and async reset.
// Expected out_run depends on COLORBUFF_RUN_EN being defined for the build.
module tb_colorbuff_fifo;
  logic clock = 1'b0;
  logic reset = 1'b0;

  int chk_cnt = 0;
  int err_cnt = 0;

  colorbuff_fifo_if #(.DATA_W(32), .DEPTH(8), .RUN_W(8)) bus ();

  colorbuff_fifo #(.DATA_W(32), .DEPTH(8), .RUN_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_run(input logic [7:0] r);
`ifdef COLORBUFF_RUN_EN
    return r;
`else
    return 8'd0 & r;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] d);
    chk("push_rdy", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] d, input logic same, input logic [7:0] run);
    chk({tag, "_vld"},  bus.out_valid, 1'b1);
    chk({tag, "_dat"},  bus.out_data, d);
    chk({tag, "_same"}, bus.out_same, same);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1 bus.out_ready = 1'b0;
    chk({tag, "_run"}, bus.out_run, exp_run(run));
  endtask

  logic [31:0] fill_v [5];

  initial begin
    fill_v[0] = 32'hFFFF; fill_v[1] = 32'h0FFF; fill_v[2] = 32'h00FF;
    fill_v[3] = 32'h000F; fill_v[4] = 32'h0000;

    // Reset then idle
    do_reset();
    @(posedge clock); #1;
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_count", bus.count, 4'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_same", bus.out_same, 1'b0);
    chk("rst_out_run", bus.out_run, 8'd0);

    // Fill and drain in order
    for (int i = 0; i < 5; i++) push_word(fill_v[i]);
    chk("fill_count", bus.count, 4'd5);
    for (int i = 0; i < 5; i++) pop_check("drain", fill_v[i], 1'b0, 8'd1);
    chk("drain_empty", bus.empty, 1'b1);

    // Full boundary
    for (int i = 0; i < 8; i++) push_word(32'h100 + i);
    chk("full_flag", bus.full, 1'b1);
    chk("full_in_ready", bus.in_ready, 1'b0);
    chk("full_count", bus.count, 4'd8);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hAAAA;
    @(posedge clock); #1;
    chk("full_refused", bus.count, 4'd8);
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("full_popush_count", bus.count, 4'd7);
    chk("full_in_ready_back", bus.in_ready, 1'b1);
    for (int i = 1; i < 8; i++) pop_check("full_drain", 32'h100 + i, 1'b0, 8'd1);
    chk("full_drain_empty", bus.empty, 1'b1);

    // Run detection from a clean reset
    do_reset();
    push_word(32'h00FF);
    push_word(32'h00FF);
    push_word(32'h00FF);
    push_word(32'h000F);
    pop_check("run0", 32'h00FF, 1'b0, 8'd1);
    pop_check("run1", 32'h00FF, 1'b1, 8'd2);
    pop_check("run2", 32'h00FF, 1'b1, 8'd3);
    pop_check("run3", 32'h000F, 1'b0, 8'd1);

    // Wrap with continuous push and pop
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 32'(i);
      #1;
      if (i == 0) chk("strm_first_empty", bus.out_valid, 1'b0);
      else        chk("strm_head", bus.out_data, 32'(i - 1));
      @(posedge clock); #1;
      chk("strm_count", bus.count, 4'd1);
    end
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    chk("strm_end_empty", bus.empty, 1'b1);

    // Async reset mid-stream
    do_reset();
    push_word(32'h55);
    pop_check("ar_pre", 32'h55, 1'b0, 8'd1);
    for (int i = 0; i < 4; i++) push_word(32'h55);
    chk("ar_count4", bus.count, 4'd4);
    chk("ar_same_before", bus.out_same, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("ar_count0", bus.count, 4'd0);
    chk("ar_out_valid", bus.out_valid, 1'b0);
    chk("ar_out_same", bus.out_same, 1'b0);
    chk("ar_out_run", bus.out_run, 8'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    push_word(32'h55);
    pop_check("ar_post", 32'h55, 1'b0, 8'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/colorbuff_fifo.md
Name: colorbuff_fifo

Overview:
- Parametrised successor of the single-register color buffer in the RLE path.
- Stores up to DEPTH color words between the pixel source and the RLE encoder, with valid/ready handshakes on both sides.
- Flags when the head word equals the previously popped word. The encoder uses this flag to extend runs without its own comparator.

Parameters:
DATA_W, 32, color word width in bits
DEPTH, 8, number of storage entries; must be a power of 2 and at least 2
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden
RUN_W, 8, run counter width; used only with COLORBUFF_RUN_EN

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  source presents in_data
in_ready  out  1  buffer can accept a word; equals !full
in_data  in  DATA_W  color word to store
out_valid  out  1  head word available; equals !empty
out_ready  in  1  encoder consumes the head word
out_data  out  DATA_W  head word (show-ahead)
out_same  out  1  head word equals last popped word
count  out  ADDR_W+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
out_run  out  RUN_W  current run length (see Optional Feature)

Behaviour:
- Reset (reset=0, async) clears the following. Deassertion is synchronous to the design by convention.
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, in_ready=1, out_valid=0.
  - last_word=0, last_vld=0, out_same=0, out_run=0.
- Reset mid-operation discards all stored words immediately. Memory contents are not cleared, but they are unreachable.
- Push occurs when in_valid && in_ready:
  - mem[wr_ptr] <= in_data.
  - wr_ptr increments and wraps from DEPTH-1 to 0.
- Pop occurs when out_valid && out_ready:
  - rd_ptr increments and wraps.
  - last_word <= out_data; last_vld <= 1.
- Occupancy:
  - Push only: count +1. Pop only: count -1. Both in one cycle: count unchanged.
- Latency and output:
  - A word pushed at edge N appears at out_data / out_valid after edge N (visible in cycle N+1).
  - There is no same-cycle bypass when empty.
  - out_data = mem[rd_ptr] combinationally. Its value is don't-care when empty.
- Full:
  - in_ready=0. A push is refused even if a pop occurs in the same cycle; in_ready rises the cycle after the pop.
- Empty:
  - out_valid=0. out_ready is ignored.
- Equality flag:
  - out_same = out_valid && last_vld && (out_data == last_word).
  - out_same is 0 for the first word after reset.
  - last_word persists across empty periods, so runs span source stalls.
- Data integrity:
  - in_data is sampled only on push.
  - The source must hold in_data and in_valid until accepted; the block does not check this.
- There is no overflow or underflow state: refused transfers have no effect.

Optional Feature:
- Macro: COLORBUFF_RUN_EN
- Defined: out_run holds the length of the current run of identical popped words.
  - Updated on each pop:
    - If last_vld && out_data == last_word, out_run increments, saturating at 2^RUN_W-1.
    - Otherwise out_run <= 1.
  - out_run is reset to 0.
- Undefined: out_run is tied to 0 and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Pulse reset low 5 ticks, no traffic.
  - Expect empty=1, full=0, count=0, in_ready=1, out_valid=0, out_same=0, out_run=0.
- Fill and drain in order:
  - Push 32'hFFFF, 32'h0FFF, 32'h00FF, 32'h000F, 32'h0000 with out_ready=0. Expect count=5.
  - Then out_ready=1. Expect pops in that exact order, out_same=0 on each, and empty after 5 pops.
- Full boundary:
  - Push 8 words with DEPTH=8. Expect full=1, in_ready=0; a 9th word (32'hAAAA) is not stored.
  - Pop one and push in the same cycle. Expect count=7, and no push accepted until the next cycle.
- Run detection:
  - Push 32'h00FF three times, then 32'h000F, and drain.
  - Expect out_same pattern 0,1,1,0.
  - With COLORBUFF_RUN_EN, expect out_run after each pop to be 1,2,3,1.
- Wrap and simultaneous push/pop:
  - Stream 20 words (value = index) with in_valid=1 and out_ready=1 continuously.
  - Expect count to stay at 1 after the first push, output order to match the index, and pointers to wrap twice without loss.
- Async reset mid-stream:
  - Assert reset between clock edges with count=4.
  - Expect count=0, out_valid=0, out_same=0 immediately, before the next edge.
  - After release, the first popped word has out_same=0.
